// File: rtl/feature_accumulator_if.sv
// Lane/handshake bundle between the product stage, the feature accumulator and the ReLU stage.
// slave = accumulator side, master = the stage driving products and consuming the aggregate.
interface feature_accumulator_if #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 21,
    parameter int CNT_W = 8
);
    logic signed [IN_W-1:0]  in0, in1, in2, in3;
    logic                    valid_in;
    logic                    last_in;
    logic signed [ACC_W-1:0] out0, out1, out2, out3;
    logic                    ready_out;
    logic [CNT_W-1:0]        count_out;
    logic                    ovf_out;

    modport master (
        output in0, in1, in2, in3, valid_in, last_in,
        input  out0, out1, out2, out3, ready_out, count_out, ovf_out
    );

    modport slave (
        input  in0, in1, in2, in3, valid_in, last_in,
        output out0, out1, out2, out3, ready_out, count_out, ovf_out
    );
endinterface

// File: rtl/feature_accumulator.sv
// Four-lane signed neighbour-sum accumulator feeding the ReLU stage; one-cycle ready_out per vector.
// Build option ACC_SAT_EN: lanes clamp on overflow instead of wrapping.
//
// state  | meaning
// S_IDLE | no open vector; next valid beat starts a fresh sum
// S_ACC  | vector open; acc_q/cnt_q/ovf_q hold the partial sum
module feature_accumulator #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 21,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    feature_accumulator_if.slave bus_if
);
    typedef enum logic {S_IDLE, S_ACC} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_MAX = '1;

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q [4];
    logic signed [ACC_W-1:0] out_q [4];
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        count_q;
    logic                    ovf_q;
    logic                    ovf_out_q;
    logic                    ready_q;

    logic signed [IN_W-1:0]  in_w  [4];
    logic signed [ACC_W:0]   sum_w [4];
    logic signed [ACC_W-1:0] lane_d [4];
    logic [3:0]              lane_ovf;
    logic [CNT_W-1:0]        cnt_d;
    logic                    ovf_d;

    assign in_w[0] = bus_if.in0;
    assign in_w[1] = bus_if.in1;
    assign in_w[2] = bus_if.in2;
    assign in_w[3] = bus_if.in3;

    // One extra bit of headroom: overflow shows up as disagreement of the top two bits.
    always_comb begin
        cnt_d = '0;
        ovf_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sum_w[k]    = '0;
            lane_d[k]   = '0;
            lane_ovf[k] = 1'b0;
            if (state_q == S_ACC) sum_w[k] = {acc_q[k][ACC_W-1], acc_q[k]};
            sum_w[k]    = sum_w[k] + (ACC_W+1)'(in_w[k]);
            lane_ovf[k] = sum_w[k][ACC_W] ^ sum_w[k][ACC_W-1];
`ifdef ACC_SAT_EN
            if (lane_ovf[k]) lane_d[k] = sum_w[k][ACC_W] ? ACC_MIN : ACC_MAX;
            else             lane_d[k] = sum_w[k][ACC_W-1:0];
`else
            lane_d[k]   = sum_w[k][ACC_W-1:0];
`endif
        end
        if (state_q == S_IDLE) begin
            cnt_d = CNT_W'(1);
            ovf_d = |lane_ovf;
        end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            ovf_d = ovf_q | (|lane_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            ovf_out_q <= 1'b0;
            ready_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                acc_q[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            ready_q <= 1'b0;
            if (bus_if.valid_in) begin
                if (bus_if.last_in) begin
                    for (int k = 0; k < 4; k++) begin
                        out_q[k] <= lane_d[k];
                        acc_q[k] <= '0;
                    end
                    count_q   <= cnt_d;
                    ovf_out_q <= ovf_d;
                    ready_q   <= 1'b1;
                    cnt_q     <= '0;
                    ovf_q     <= 1'b0;
                    state_q   <= S_IDLE;
                end else begin
                    for (int k = 0; k < 4; k++) acc_q[k] <= lane_d[k];
                    cnt_q   <= cnt_d;
                    ovf_q   <= ovf_d;
                    state_q <= S_ACC;
                end
            end
        end
    end

    assign bus_if.out0      = out_q[0];
    assign bus_if.out1      = out_q[1];
    assign bus_if.out2      = out_q[2];
    assign bus_if.out3      = out_q[3];
    assign bus_if.ready_out = ready_q;
    assign bus_if.count_out = count_q;
    assign bus_if.ovf_out   = ovf_out_q;
endmodule

// File: tb/tb_feature_accumulator.sv
// Bench for feature_accumulator: directed scenarios plus random vectors against an integer-arithmetic model.
// Honours ACC_SAT_EN the same way the design does.
module tb_feature_accumulator;
    localparam int IN_W  = 16;
    localparam int ACC_W = 21;
    localparam int CNT_W = 8;
    localparam longint VMAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint VMIN = -(longint'(1) <<< (ACC_W-1));
    localparam longint SPAN = longint'(1) <<< ACC_W;
    localparam int     CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    feature_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    feature_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    logic signed [ACC_W-1:0] dut_out [4];
    assign dut_out[0] = bus.out0;
    assign dut_out[1] = bus.out1;
    assign dut_out[2] = bus.out2;
    assign dut_out[3] = bus.out3;

    // Reference model: plain integer sums, range check, then wrap or clamp.
    longint m_acc [4];
    longint m_out [4];
    longint m_in  [4];
    int     m_cnt, m_cnt_out;
    bit     m_open, m_ovf, m_ovf_out, m_strobe;

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = 0;
            m_out[k] = 0;
        end
        m_cnt = 0; m_cnt_out = 0; m_open = 0; m_ovf = 0; m_ovf_out = 0; m_strobe = 0;
    endfunction

    function automatic void model_beat(input bit v, input bit l);
        longint s [4];
        bit     ov;
        m_strobe = 0;
        if (!v) return;
        ov = 0;
        for (int k = 0; k < 4; k++) begin
            s[k] = (m_open ? m_acc[k] : 0) + m_in[k];
            if (s[k] > VMAX || s[k] < VMIN) begin
                ov = 1;
`ifdef ACC_SAT_EN
                s[k] = (s[k] > VMAX) ? VMAX : VMIN;
`else
                s[k] = (s[k] > VMAX) ? s[k] - SPAN : s[k] + SPAN;
`endif
            end
        end
        if (!m_open) begin
            m_cnt = 1;
            m_ovf = ov;
        end else begin
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            m_ovf = m_ovf | ov;
        end
        if (l) begin
            for (int k = 0; k < 4; k++) begin
                m_out[k] = s[k];
                m_acc[k] = 0;
            end
            m_cnt_out = m_cnt;
            m_ovf_out = m_ovf;
            m_strobe  = 1;
            m_open    = 0;
        end else begin
            for (int k = 0; k < 4; k++) m_acc[k] = s[k];
            m_open = 1;
        end
    endfunction

    function automatic longint rnd_lane();
        logic signed [IN_W-1:0] t;
        t = IN_W'($urandom);
        return longint'(t);
    endfunction

    // Drive one cycle at the falling edge, let the model follow, sample 1 time unit after the rising edge.
    task automatic drive(input bit v, input bit l, input longint a, input longint b,
                         input longint c, input longint d);
        @(negedge clk);
        m_in[0] = a; m_in[1] = b; m_in[2] = c; m_in[3] = d;
        bus.valid_in = v;
        bus.last_in  = l;
        bus.in0 = IN_W'(a);
        bus.in1 = IN_W'(b);
        bus.in2 = IN_W'(c);
        bus.in3 = IN_W'(d);
        model_beat(v, l);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input bit with_valid);
        @(negedge clk);
        rst = 1'b1;
        bus.valid_in = with_valid;
        bus.last_in  = 1'b1;
        bus.in0 = 16'sd123; bus.in1 = 16'sd1; bus.in2 = 16'sd2; bus.in3 = 16'sd3;
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        checks++; if (bus.ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", bus.ready_out); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut_out[k] !== '0) begin failures++; $display("FAIL reset_out%0d got=%0d exp=0", k, dut_out[k]); end
        end
        checks++; if (bus.count_out !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count_out); end
        checks++; if (bus.ovf_out !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf_out); end
    endtask

    task automatic test_basic();
        drive(1, 0, 100, 0, 0, 0);
        checks++; if (bus.ready_out !== 1'b0) begin failures++; $display("FAIL basic_early_strobe beat1 got=%0b exp=0", bus.ready_out); end
        drive(1, 0, 200, 0, 0, 0);
        checks++; if (bus.ready_out !== 1'b0) begin failures++; $display("FAIL basic_early_strobe beat2 got=%0b exp=0", bus.ready_out); end
        drive(1, 1, -50, 0, 0, 0);
        checks++; if (bus.ready_out !== 1'b1) begin failures++; $display("FAIL basic_strobe got=%0b exp=1", bus.ready_out); end
        checks++; if (longint'(dut_out[0]) != 250) begin failures++; $display("FAIL basic_out0 got=%0d exp=250", dut_out[0]); end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (dut_out[k] !== '0) begin failures++; $display("FAIL basic_out%0d got=%0d exp=0", k, dut_out[k]); end
        end
        checks++; if (bus.count_out !== 8'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", bus.count_out); end
        checks++; if (bus.ovf_out !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%0b exp=0", bus.ovf_out); end
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.ready_out !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%0b exp=0", bus.ready_out); end
        checks++; if (longint'(dut_out[0]) != 250) begin failures++; $display("FAIL basic_hold_out0 got=%0d exp=250", dut_out[0]); end
    endtask

    task automatic test_single();
        drive(1, 1, -1, 32767, -32768, 5);
        checks++; if (bus.ready_out !== 1'b1) begin failures++; $display("FAIL single_strobe got=%0b exp=1", bus.ready_out); end
        checks++;
        if (longint'(dut_out[0]) != -1 || longint'(dut_out[1]) != 32767 ||
            longint'(dut_out[2]) != -32768 || longint'(dut_out[3]) != 5) begin
            failures++;
            $display("FAIL single_lanes got=%0d,%0d,%0d,%0d exp=-1,32767,-32768,5",
                     dut_out[0], dut_out[1], dut_out[2], dut_out[3]);
        end
        checks++; if (bus.count_out !== 8'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.count_out); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_overflow();
        longint exp0;
`ifdef ACC_SAT_EN
        exp0 = 1048575;
`else
        exp0 = -786472;
`endif
        for (int i = 0; i < 40; i++) drive(1, (i == 39), 32767, 0, 0, 0);
        checks++; if (bus.ready_out !== 1'b1) begin failures++; $display("FAIL ovf_strobe got=%0b exp=1", bus.ready_out); end
        checks++; if (bus.ovf_out !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", bus.ovf_out); end
        checks++; if (longint'(dut_out[0]) != exp0) begin failures++; $display("FAIL ovf_out0 got=%0d exp=%0d", dut_out[0], exp0); end
        checks++; if (longint'(dut_out[0]) != m_out[0]) begin failures++; $display("FAIL ovf_model_out0 got=%0d exp=%0d", dut_out[0], m_out[0]); end
        checks++; if (bus.count_out !== 8'd40) begin failures++; $display("FAIL ovf_count got=%0d exp=40", bus.count_out); end
        drive(1, 1, 1, 0, 0, 0);
        checks++; if (bus.ovf_out !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%0b exp=0", bus.ovf_out); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 10, 0, 0, 0);
        drive(1, 1, 10, 0, 0, 0);
        checks++; if (bus.ready_out !== 1'b1) begin failures++; $display("FAIL b2b_strobe_a got=%0b exp=1", bus.ready_out); end
        checks++; if (longint'(dut_out[0]) != 20) begin failures++; $display("FAIL b2b_out0_a got=%0d exp=20", dut_out[0]); end
        checks++; if (bus.count_out !== 8'd2) begin failures++; $display("FAIL b2b_count_a got=%0d exp=2", bus.count_out); end
        drive(1, 1, 7, 0, 0, 0);
        checks++; if (bus.ready_out !== 1'b1) begin failures++; $display("FAIL b2b_strobe_b got=%0b exp=1", bus.ready_out); end
        checks++; if (longint'(dut_out[0]) != 7) begin failures++; $display("FAIL b2b_out0_b got=%0d exp=7", dut_out[0]); end
        checks++; if (bus.count_out !== 8'd1) begin failures++; $display("FAIL b2b_count_b got=%0d exp=1", bus.count_out); end
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.ready_out !== 1'b0) begin failures++; $display("FAIL b2b_after got=%0b exp=0", bus.ready_out); end
    endtask

    task automatic test_gap();
        drive(1, 0, 5, 1, 0, 0);
        drive(1, 0, 6, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
            checks++; if (bus.ready_out !== 1'b0) begin failures++; $display("FAIL gap_strobe cycle=%0d got=%0b exp=0", i, bus.ready_out); end
            checks++; if (longint'(dut_out[0]) != m_out[0]) begin failures++; $display("FAIL gap_hold cycle=%0d got=%0d exp=%0d", i, dut_out[0], m_out[0]); end
        end
        drive(1, 1, 7, 1, 0, 0);
        checks++; if (bus.ready_out !== 1'b1) begin failures++; $display("FAIL gap_strobe_final got=%0b exp=1", bus.ready_out); end
        checks++; if (longint'(dut_out[0]) != 18) begin failures++; $display("FAIL gap_out0 got=%0d exp=18", dut_out[0]); end
        checks++; if (longint'(dut_out[1]) != 3) begin failures++; $display("FAIL gap_out1 got=%0d exp=3", dut_out[1]); end
        checks++; if (bus.count_out !== 8'd3) begin failures++; $display("FAIL gap_count got=%0d exp=3", bus.count_out); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 30, 30, 30, 30);
        drive(1, 0, 40, 40, 40, 40);
        apply_reset(1'b0);
        checks++; if (bus.ready_out !== 1'b0) begin failures++; $display("FAIL rmid_strobe got=%0b exp=0", bus.ready_out); end
        checks++; if (dut_out[0] !== '0) begin failures++; $display("FAIL rmid_out0 got=%0d exp=0", dut_out[0]); end
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.ready_out !== 1'b0) begin failures++; $display("FAIL rmid_no_pulse got=%0b exp=0", bus.ready_out); end
        drive(1, 1, 9, 0, 0, 0);
        checks++; if (longint'(dut_out[0]) != 9) begin failures++; $display("FAIL rmid_fresh_out0 got=%0d exp=9", dut_out[0]); end
        checks++; if (bus.count_out !== 8'd1) begin failures++; $display("FAIL rmid_fresh_count got=%0d exp=1", bus.count_out); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 300; i++) drive(1, (i == 299), 1, -1, 0, 2);
        checks++; if (bus.count_out !== 8'd255) begin failures++; $display("FAIL csat_count got=%0d exp=255", bus.count_out); end
        checks++; if (bus.ovf_out !== 1'b0) begin failures++; $display("FAIL csat_ovf got=%0b exp=0", bus.ovf_out); end
        checks++; if (longint'(dut_out[0]) != 300 || longint'(dut_out[1]) != -300) begin
            failures++; $display("FAIL csat_sum got=%0d,%0d exp=300,-300", dut_out[0], dut_out[1]);
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // Random vectors with random idle gaps; every sampled cycle is compared against the model.
    task automatic test_random();
        int  len;
        bool_check: for (int v = 0; v < 40; v++) begin
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                while ($urandom_range(0, 3) == 0) begin
                    drive(0, $urandom_range(0, 1), rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
                    checks++;
                    if (bus.ready_out !== m_strobe) begin failures++; $display("FAIL rand_idle_strobe vec=%0d got=%0b exp=%0b", v, bus.ready_out, m_strobe); end
                end
                if (v % 5 == 0)
                    drive(1, (b == len - 1), 32767 - $urandom_range(0, 3), -32768, rnd_lane(), rnd_lane());
                else
                    drive(1, (b == len - 1), rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
                checks++;
                if (bus.ready_out !== m_strobe) begin failures++; $display("FAIL rand_strobe vec=%0d beat=%0d got=%0b exp=%0b", v, b, bus.ready_out, m_strobe); end
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (longint'(dut_out[k]) != m_out[k]) begin
                        failures++; $display("FAIL rand_out%0d vec=%0d beat=%0d got=%0d exp=%0d", k, v, b, dut_out[k], m_out[k]);
                    end
                end
                checks++;
                if (int'(bus.count_out) != m_cnt_out) begin failures++; $display("FAIL rand_count vec=%0d got=%0d exp=%0d", v, bus.count_out, m_cnt_out); end
                checks++;
                if (bus.ovf_out !== m_ovf_out) begin failures++; $display("FAIL rand_ovf vec=%0d got=%0b exp=%0b", v, bus.ovf_out, m_ovf_out); end
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
        bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
        model_reset();
        test_reset();
        test_basic();
        test_single();
        test_overflow();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        test_count_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/feature_accumulator.md
Name: feature_accumulator

Overview:
- Upstream neighbour of the four-lane ReLU stage in the GNN datapath.
- Sums per-neighbour signed product vectors (4 lanes) over a variable-length neighbour list delimited by a last flag.
- Presents the 21-bit aggregated vector with a one-cycle ready_out strobe that drives the ReLU ready_in directly.

Parameters:
- IN_W, 16, width of each signed input product lane.
- ACC_W, 21, width of each signed accumulator/output lane; must match the ReLU lane width.
- CNT_W, 8, width of the neighbour-term counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in0, in1, in2, in3  input  IN_W each  signed product lanes for one neighbour.
- valid_in  input  1  beat qualifier; lanes and last_in sampled only when high.
- last_in  input  1  marks the final beat of the current neighbour list; ignored when valid_in low.
- out0, out1, out2, out3  output  ACC_W each  signed aggregated lanes; feeds ReLU in0..in3.
- ready_out  output  1  one-cycle strobe: out0..out3/count_out/ovf_out are valid.
- count_out  output  CNT_W  number of beats summed into the presented vector.
- ovf_out  output  1  at least one lane overflowed ACC_W during the presented vector.

Behaviour:
- Reset: synchronous; on rst high at an edge: state IDLE, all accumulators 0, out0..out3 0, ready_out 0, count_out 0, ovf_out 0, internal count 0, sticky overflow 0. rst overrides any concurrent valid_in.
- Reset mid-vector: partial sum discarded, no ready_out pulse; next valid beat starts a fresh vector.
- States: IDLE (no open vector), ACC (vector open).
- IDLE + valid_in & !last_in: acc_k <= sext(in_k), count <= 1, ovf <= 0, -> ACC.
- IDLE + valid_in & last_in: single-beat vector; out_k <= sext(in_k), count_out <= 1, ovf_out <= 0, ready_out <= 1; stay IDLE.
- ACC + valid_in & !last_in: acc_k <= acc_k + sext(in_k); count += 1; ovf |= lane overflow.
- ACC + valid_in & last_in: out_k <= acc_k + sext(in_k); count_out <= count+1; ovf_out <= ovf | overflow on this add; ready_out <= 1; acc cleared; -> IDLE.
- valid_in low: accumulators and count hold; no output change; no timeout.
- Latency: ready_out asserts exactly one cycle after the edge sampling the last beat; high for exactly one cycle.
- Back-to-back: first beat of the next vector accepted in the cycle right after a last beat (while ready_out is high); no bubble required or inserted.
- Outputs out_k, count_out, ovf_out hold their values between strobes; change only on a strobe edge or reset.
- Arithmetic: inputs sign-extended IN_W -> ACC_W; adds in ACC_W+1 bits; overflow = result outside [-2^(ACC_W-1), 2^(ACC_W-1)-1], detected per lane, ORed across lanes.
- Count: saturates at 2^CNT_W-1 (no wrap); saturation does not set ovf_out.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined: on overflow a lane clamps to 2^(ACC_W-1)-1 (positive) or -2^(ACC_W-1) (negative); later beats continue from the clamped value.
- Undefined: two's-complement wrap to ACC_W bits.
- ovf_out is reported identically in both builds.

Test Plan:
- Reset then 3 beats lane0 = 100, 200, -50 (last on 3rd), other lanes 0 -> one cycle after the 3rd beat: ready_out=1 for 1 cycle, out0=250, out1..3=0, count_out=3, ovf_out=0.
- Single beat in0..in3 = -1, 32767, -32768, 5 with valid_in & last_in -> next cycle out = -1, 32767, -32768, 5, count_out=1.
- 40 beats lane0 = 32767 -> sum 1310680 > 1048575: ovf_out=1; with ACC_SAT_EN out0=1048575, without out0=1310680-2097152=-786472.
- Back-to-back: vector A (2 beats of 10) then vector B (1 beat of 7) with no gap -> two ready_out pulses on consecutive-phase cycles, out0=20 then out0=7; vector B counts start at 1.
- valid_in low for 5 cycles mid-vector, and last_in=1 with valid_in=0 -> no strobe, no state change; final sum unaffected.
- rst asserted after 2 of 4 beats -> no ready_out, outputs 0; following 1-beat vector of 9 -> out0=9, count_out=1.
